sand_drop_ctrl: RTL and testbench

// - Write-side initiator for the sand array: turns user buttons and an auto-rate setting into drop requests
//   (drop_o, drop_x_o, drop_y_o) that feed the array's drop_i/drop_x/drop_y inputs.
// - Keeps a cursor clamped to the active resolution and issues at most one drop per frame,

---
 rtl/sandpile_pkg.sv | 38 +++
 rtl/sand_drop_ctrl_debounce.sv | 43 ++++
 rtl/sand_drop_ctrl.sv | 156 +++++++++++++++
 tb/tb_sand_drop_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sandpile_pkg.sv
// Shared types and constants for the sand array write side: coordinates, button directions, LFSR constants.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package sandpile_pkg;

    localparam int COORD_W = 9;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } issue_state_t;

    // Galois form, right-shifting, taps 16,14,13,11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic coord_t eff_res(input coord_t res, input coord_t max_size);
        if (res == '0)
            return coord_t'(1);
        else if (res > max_size)
            return max_size;
        else
            return res;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sand_drop_ctrl_debounce.sv
// Button conditioner: 2-flop synchroniser plus counter debounce; level flips after DEBOUNCE_CYCLES stable cycles.
// Rise pulse is registered alongside the level flip; no backpressure, the pulse is lost if not consumed.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == level) begin
                // any return to the current level restarts the stability window
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync_q2;
                rise  <= sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sand_drop_ctrl.sv
// Drop initiator for the sand array: cursor control, manual/auto drops, one drop per frame; drop_o 1 cycle after new_frame_i.
// No backpressure: the array accepts every strobe. Define SANDDROP_RANDOM_EN for LFSR-placed auto drops.
module sand_drop_ctrl
    import sandpile_pkg::*;
#(
    parameter int MAX_SIZE        = 32,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RATE_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame_i,
    input  logic [COORD_W-1:0] resolution_i,
    input  logic               btn_up_i,
    input  logic               btn_down_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    input  logic               btn_drop_i,
    input  logic               auto_en_i,
    input  logic [RATE_W-1:0]  auto_rate_i,
    output logic               drop_o,
    output logic [COORD_W-1:0] drop_x_o,
    output logic [COORD_W-1:0] drop_y_o,
    output logic [COORD_W-1:0] cursor_x_o,
    output logic [COORD_W-1:0] cursor_y_o
);

    localparam int BTN_DROP = 4;

    logic [4:0] btn_raw;
    logic [4:0] btn_lvl;
    logic [4:0] btn_rise;

    assign btn_raw = {btn_drop_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .level(btn_lvl[i]),
            .rise (btn_rise[i])
        );
    end

    logic step_up, step_down, step_left, step_right;

    assign step_up    = btn_rise[int'(DIR_UP)];
    assign step_down  = btn_rise[int'(DIR_DOWN)];
    assign step_left  = btn_rise[int'(DIR_LEFT)];
    assign step_right = btn_rise[int'(DIR_RIGHT)];

    coord_t res_eff;
    coord_t res_max;
    coord_t cur_x;
    coord_t cur_y;

    assign res_eff = eff_res(resolution_i, coord_t'(MAX_SIZE));
    assign res_max = res_eff - coord_t'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (cur_x > res_max || cur_y > res_max) begin
            // a shrink takes priority; button steps in this cycle are dropped
            if (cur_x > res_max) cur_x <= res_max;
            if (cur_y > res_max) cur_y <= res_max;
        end else begin
            if (step_right && !step_left && cur_x < res_max)
                cur_x <= cur_x + coord_t'(1);
            else if (step_left && !step_right && cur_x != '0)
                cur_x <= cur_x - coord_t'(1);
            if (step_down && !step_up && cur_y < res_max)
                cur_y <= cur_y + coord_t'(1);
            else if (step_up && !step_down && cur_y != '0)
                cur_y <= cur_y - coord_t'(1);
        end
    end

    assign cursor_x_o = cur_x;
    assign cursor_y_o = cur_y;

    coord_t auto_x;
    coord_t auto_y;

`ifdef SANDDROP_RANDOM_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_next(lfsr);
    end

    assign auto_x = coord_t'(lfsr[8:0] % res_eff);
    assign auto_y = coord_t'(lfsr[15:7] % res_eff);
`else
    assign auto_x = cur_x;
    assign auto_y = cur_y;
`endif

    logic [RATE_W-1:0] frame_cnt;
    logic              auto_due;
    logic              pending;
    issue_state_t      state;

    assign auto_due = auto_en_i && new_frame_i && (frame_cnt == auto_rate_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (!auto_en_i) begin
            frame_cnt <= '0;
        end else if (new_frame_i) begin
            frame_cnt <= auto_due ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            drop_o   <= 1'b0;
            drop_x_o <= '0;
            drop_y_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_rise[BTN_DROP])
                        pending <= 1'b1;
                    if (new_frame_i && (pending || auto_due)) begin
                        // manual request owns the position when both are due
                        state    <= ST_ISSUE;
                        drop_o   <= 1'b1;
                        drop_x_o <= pending ? cur_x : auto_x;
                        drop_y_o <= pending ? cur_y : auto_y;
                    end
                end
                ST_ISSUE: begin
                    state   <= ST_IDLE;
                    drop_o  <= 1'b0;
                    pending <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    drop_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sand_drop_ctrl.sv
// Directed bench for sand_drop_ctrl with DEBOUNCE_CYCLES=4, MAX_SIZE=32.
module tb_sand_drop_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_frame_i;
    logic [8:0] resolution_i;
    logic       btn_up_i, btn_down_i, btn_left_i, btn_right_i, btn_drop_i;
    logic       auto_en_i;
    logic [3:0] auto_rate_i;
    logic       drop_o;
    logic [8:0] drop_x_o, drop_y_o, cursor_x_o, cursor_y_o;

    int n_cmp = 0;
    int n_bad = 0;

    sand_drop_ctrl #(
        .MAX_SIZE       (32),
        .DEBOUNCE_CYCLES(4),
        .RATE_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_frame_i (new_frame_i),
        .resolution_i(resolution_i),
        .btn_up_i    (btn_up_i),
        .btn_down_i  (btn_down_i),
        .btn_left_i  (btn_left_i),
        .btn_right_i (btn_right_i),
        .btn_drop_i  (btn_drop_i),
        .auto_en_i   (auto_en_i),
        .auto_rate_i (auto_rate_i),
        .drop_o      (drop_o),
        .drop_x_o    (drop_x_o),
        .drop_y_o    (drop_y_o),
        .cursor_x_o  (cursor_x_o),
        .cursor_y_o  (cursor_y_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // button ids: 0 up, 1 down, 2 left, 3 right, 4 drop
    task automatic set_btn(input int id, input logic v);
        case (id)
            0: btn_up_i    = v;
            1: btn_down_i  = v;
            2: btn_left_i  = v;
            3: btn_right_i = v;
            default: btn_drop_i = v;
        endcase
    endtask

    task automatic press(input int id);
        set_btn(id, 1'b1);
        repeat (6) @(negedge clk);
        set_btn(id, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    // one-cycle frame tick; returns what the drop interface shows the cycle after
    task automatic tick(output logic d, output logic [8:0] x, output logic [8:0] y);
        new_frame_i = 1'b1;
        @(negedge clk);
        new_frame_i = 1'b0;
        d = drop_o;
        x = drop_x_o;
        y = drop_y_o;
        repeat (3) @(negedge clk);
    endtask

    logic       d;
    logic [8:0] x, y;

    initial begin
        rst = 1'b1;
        new_frame_i = 1'b0;
        resolution_i = 9'd32;
        btn_up_i = 1'b0; btn_down_i = 1'b0; btn_left_i = 1'b0; btn_right_i = 1'b0; btn_drop_i = 1'b0;
        auto_en_i = 1'b0;
        auto_rate_i = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_drop", 16'(drop_o), 16'd0);
        check("reset_drop_x", 16'(drop_x_o), 16'd0);
        check("reset_drop_y", 16'(drop_y_o), 16'd0);
        check("reset_cur_x", 16'(cursor_x_o), 16'd0);
        check("reset_cur_y", 16'(cursor_y_o), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        press(3); press(3); press(3);
        press(1); press(1);
        check("move_cur_x", 16'(cursor_x_o), 16'd3);
        check("move_cur_y", 16'(cursor_y_o), 16'd2);
        check("no_drop_without_tick", 16'(drop_o), 16'd0);

        // bounce 1-1-0-1-1 never holds 4 synchronised cycles
        btn_right_i = 1'b1; repeat (2) @(negedge clk);
        btn_right_i = 1'b0; @(negedge clk);
        btn_right_i = 1'b1; repeat (2) @(negedge clk);
        btn_right_i = 1'b0; repeat (12) @(negedge clk);
        check("bounce_cur_x", 16'(cursor_x_o), 16'd3);

        press(4);
        check("pending_no_drop", 16'(drop_o), 16'd0);
        tick(d, x, y);
        check("manual_drop", 16'(d), 16'd1);
        check("manual_drop_x", 16'(x), 16'd3);
        check("manual_drop_y", 16'(y), 16'd2);
        check("manual_drop_one_cycle", 16'(drop_o), 16'd0);
        tick(d, x, y);
        check("second_tick_no_drop", 16'(d), 16'd0);
        check("drop_x_held", 16'(x), 16'd3);

        for (int i = 0; i < 28; i++) press(3);
        for (int i = 0; i < 29; i++) press(1);
        check("corner_cur_x", 16'(cursor_x_o), 16'd31);
        check("corner_cur_y", 16'(cursor_y_o), 16'd31);
        press(3);
        check("right_sat_31", 16'(cursor_x_o), 16'd31);
        resolution_i = 9'd16;
        @(negedge clk);
        check("shrink_cur_x", 16'(cursor_x_o), 16'd15);
        check("shrink_cur_y", 16'(cursor_y_o), 16'd15);
        press(3);
        check("right_sat_15", 16'(cursor_x_o), 16'd15);

        auto_en_i = 1'b1;
        auto_rate_i = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            if (k == 6) press(4);
            tick(d, x, y);
            check($sformatf("auto_tick%0d", k), 16'(d), (k % 3 == 0) ? 16'd1 : 16'd0);
            if (k == 6) begin
                check("auto_manual_x", 16'(x), 16'd15);
                check("auto_manual_y", 16'(y), 16'd15);
            end
        end
        auto_en_i = 1'b0;

        press(4);
        new_frame_i = 1'b1;
        @(negedge clk);
        new_frame_i = 1'b0;
        check("issue_before_reset", 16'(drop_o), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_issue_drop", 16'(drop_o), 16'd0);
        check("reset_mid_issue_cur_x", 16'(cursor_x_o), 16'd0);
        check("reset_mid_issue_cur_y", 16'(cursor_y_o), 16'd0);
        check("reset_mid_issue_drop_x", 16'(drop_x_o), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        tick(d, x, y);
        check("pending_lost", 16'(d), 16'd0);

        press(3); press(3); press(1);
        check("res16_cur_x", 16'(cursor_x_o), 16'd2);
        resolution_i = 9'd0;
        repeat (2) @(negedge clk);
        check("res0_cur_x", 16'(cursor_x_o), 16'd0);
        check("res0_cur_y", 16'(cursor_y_o), 16'd0);
        press(3);
        check("res0_right_sat", 16'(cursor_x_o), 16'd0);

`ifdef SANDDROP_RANDOM_EN
        begin
            logic [8:0] fx, fy;
            int         n_drop;
            int         n_diff;
            resolution_i = 9'd8;
            auto_rate_i  = 4'd0;
            auto_en_i    = 1'b1;
            n_drop = 0;
            n_diff = 0;
            fx = '0;
            fy = '0;
            @(negedge clk);
            for (int k = 0; k < 50; k++) begin
                tick(d, x, y);
                if (d) begin
                    if (n_drop == 0) begin
                        fx = x;
                        fy = y;
                    end else if (x != fx || y != fy) begin
                        n_diff++;
                    end
                    n_drop++;
                end
                check("rand_x_range", 16'(x < 9'd8), 16'd1);
                check("rand_y_range", 16'(y < 9'd8), 16'd1);
            end
            check("rand_drop_count", 16'(n_drop), 16'd50);
            check("rand_not_all_equal", 16'(n_diff > 0), 16'd1);
            auto_en_i = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
